// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered N-bit ALU with valid/ready handshake and a shift-add multiplier
`timescale 1ns/1ps
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SLT  = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_XOR  = 3'b111;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 cout_q, cout_d;
   logic                 ovf_q, ovf_d;
   logic                 zero_q, zero_d;
   logic                 out_valid_q, out_valid_d;

   logic                 accept;
   logic                 mul_start;
   logic                 mul_last;
   logic [WIDTH-1:0]     b_eff;
   logic [WIDTH:0]       sum;
   logic                 add_ovf;
   logic [WIDTH-1:0]     res;
   logic                 res_c;
   logic                 res_v;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mul_start) state_d = MUL;
         MUL:     if (mul_last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy     = (state_q == MUL);
      in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   end

   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (sel == OP_MUL);
   assign mul_last  = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH - 1));

   // SUB shares the adder as A + ~B + 1 so cout means "no borrow"
   always_comb begin
      b_eff   = (sel == OP_SUB) ? ~B : B;
      sum     = {1'b0, A} + {1'b0, b_eff} + (WIDTH+1)'(sel == OP_SUB);
      add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      case (sel)
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_ADD, OP_SUB: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = add_ovf;
         end
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, A < B};
         default: res = '0;
      endcase
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (mul_start) begin
         mcand_d  = {{WIDTH{1'b0}}, A};
         mplier_d = B;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (state_q == MUL) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   // A fresh result wins over the drain, so simultaneous drain + accept keeps out_valid high
   always_comb begin
      out_d       = out_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      if (accept && (sel != OP_MUL)) begin
         out_d       = res;
         cout_d      = res_c;
         ovf_d       = res_v;
         zero_d      = (res == '0);
         out_valid_d = 1'b1;
      end else if (mul_last) begin
         out_d       = acc_d[WIDTH-1:0];
         cout_d      = |acc_d[2*WIDTH-1:WIDTH];
         ovf_d       = 1'b0;
         zero_d      = (acc_d[WIDTH-1:0] == '0);
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
`timescale 1ns/1ps
module tb_alu_seq;
   localparam int W = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SLT  = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_XOR  = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         cout;
   logic         overflow;
   logic         zero;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      sel      = s;
      A        = a;
      B        = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // exp_flags = {out_valid, cout, overflow, zero}
   task automatic alu_op(input string tag, input logic [2:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_out, input logic [3:0] exp_flags);
      issue(s, a, b);
      chk({tag, "_out"}, out, exp_out);
      chk({tag, "_flags"}, {out_valid, cout, overflow, zero}, exp_flags);
   endtask

   task automatic mul_wait(output int edges, output int busy_cycles, output int ready_in_busy);
      edges         = 0;
      busy_cycles   = busy ? 1 : 0;
      ready_in_busy = (busy && in_ready) ? 1 : 0;
      while (!out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (busy) busy_cycles++;
         if (busy && in_ready) ready_in_busy++;
      end
   endtask

   initial begin
      int edges;
      int busy_cycles;
      int ready_in_busy;
      int seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      sel       = OP_AND;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", out, 32'h0);
      chk("rst_flags", {out_valid, cout, overflow, zero}, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      alu_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1101);
      alu_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010);
      alu_op("sub_neg",  OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000);
      alu_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1110);
      alu_op("slt",      OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b1000);
      alu_op("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001);
      alu_op("and",      OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
      alu_op("or",       OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b1000);
      alu_op("xor",      OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b1000);

      // MUL with 2^32 product; inputs driven during MUL must be ignored
      issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
      chk("mul1_busy", busy, 1'b1);
      chk("mul1_in_ready", in_ready, 1'b0);
      in_valid = 1'b1;
      sel      = OP_ADD;
      A        = 32'h1;
      B        = 32'h1;
      mul_wait(edges, busy_cycles, ready_in_busy);
      in_valid = 1'b0;
      chk("mul1_latency", edges, 32);
      chk("mul1_busy_cycles", busy_cycles, 32);
      chk("mul1_ready_in_busy", ready_in_busy, 0);
      chk("mul1_out", out, 32'h0);
      chk("mul1_flags", {out_valid, cout, overflow, zero}, 4'b1101);

      issue(OP_MUL, 32'd1234, 32'd5678);
      mul_wait(edges, busy_cycles, ready_in_busy);
      chk("mul2_latency", edges, 32);
      chk("mul2_out", out, 32'd7006652);
      chk("mul2_flags", {out_valid, cout, overflow, zero}, 4'b1000);
      @(posedge clk);
      #1;
      chk("mul2_drained", out_valid, 1'b0);

      // back-pressure
      out_ready = 1'b0;
      issue(OP_ADD, 32'd1, 32'd2);
      chk("bp_first_out", out, 32'd3);
      chk("bp_first_ready", in_ready, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      sel      = OP_ADD;
      A        = 32'd10;
      B        = 32'd20;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("bp_hold_out", out, 32'd3);
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", in_ready, 1'b1);
      @(posedge clk);
      #1;
      chk("bp_drain2_out", out, 32'd30);
      chk("bp_drain2_valid", out_valid, 1'b1);
      @(negedge clk);
      A = 32'd100;
      B = 32'd200;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_drain3_out", out, 32'd300);
      chk("bp_drain3_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      chk("bp_empty", out_valid, 1'b0);

      // reset in the middle of a multiply
      issue(OP_MUL, 32'd1234, 32'd5678);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_out", out, 32'h0);
      chk("mrst_flags", {out_valid, cout, overflow, zero}, 4'b0000);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) seen++;
      end
      chk("mrst_no_result", seen, 0);
      alu_op("mrst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
